// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue
//   First-word-fall-through command FIFO that feeds the 8-bit right barrel
//   shifter. Each entry is a {data, shift amount} pair. The head entry is
//   always visible on m_data/m_shift while m_valid is high. When the queue is
//   empty, these outputs are forced to zero.
//
// Parameters
//   DATA_W  : data word width (shifter data input)
//   SHIFT_W : shift amount width (shifter shift input)
//   DEPTH   : number of entries; must be a power of two and at least 2
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   s_valid/s_ready          : producer handshake
//   s_data/s_shift           : incoming command
//   m_valid/m_ready          : consumer handshake
//   m_data/m_shift           : head command, presented combinationally
//   count/full/empty         : occupancy status
//   drop_err                 : present only when SHIFT_CMD_QUEUE_ERR_EN is
//                              defined. Sticky flag that sets when the
//                              producer offers a command while the queue is
//                              full. Only rst clears it.
module shift_cmd_queue #(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 3,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  input  logic [SHIFT_W-1:0]         s_shift,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [SHIFT_W-1:0]         m_shift,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
`ifdef SHIFT_CMD_QUEUE_ERR_EN
  ,
  output logic                       drop_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0]  data_mem  [DEPTH];
  logic [SHIFT_W-1:0] shift_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  // Gating s_ready with rst keeps the reset edge from accepting a command.
  assign s_ready = !full && !rst;
  assign m_valid = !empty;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Head is read straight from storage, so a push into an empty queue is visible one cycle later.
  assign m_data  = empty ? '0 : data_mem[rd_ptr];
  assign m_shift = empty ? '0 : shift_mem[rd_ptr];

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage: not reset, because only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= s_data;
      shift_mem[wr_ptr] <= s_shift;
    end
  end

`ifdef SHIFT_CMD_QUEUE_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err <= 1'b0;
    end else if (s_valid && full) begin
      drop_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
module tb_shift_cmd_queue;

  localparam int DATA_W  = 8;
  localparam int SHIFT_W = 3;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [DATA_W-1:0]  s_data;
  logic [SHIFT_W-1:0] s_shift;
  logic               m_valid;
  logic               m_ready;
  logic [DATA_W-1:0]  m_data;
  logic [SHIFT_W-1:0] m_shift;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
`ifdef SHIFT_CMD_QUEUE_ERR_EN
  logic               drop_err;
  logic               exp_drop;
`endif

  shift_cmd_queue #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_shift (s_shift),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_shift (m_shift),
    .count   (count),
    .full    (full),
    .empty   (empty)
`ifdef SHIFT_CMD_QUEUE_ERR_EN
    ,
    .drop_err(drop_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0]  d;
    logic [SHIFT_W-1:0] s;
  } cmd_t;

  cmd_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  function automatic logic [DATA_W-1:0] shifter(input logic [DATA_W-1:0] d,
                                                input logic [SHIFT_W-1:0] s);
    return d >> s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all visible outputs against the model, outside the clock edge.
  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(exp_cnt));
    chk({tag, ".full"}, 32'(full), 32'(exp_cnt == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(exp_cnt == 0));
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(exp_cnt != 0));
    chk({tag, ".s_ready"}, 32'(s_ready), 32'((exp_cnt != DEPTH) && !rst));
    if (sb.size() != 0) begin
      chk({tag, ".m_data"}, 32'(m_data), 32'(sb[0].d));
      chk({tag, ".m_shift"}, 32'(m_shift), 32'(sb[0].s));
    end else begin
      chk({tag, ".m_data0"}, 32'(m_data), 32'h0);
      chk({tag, ".m_shift0"}, 32'(m_shift), 32'h0);
    end
`ifdef SHIFT_CMD_QUEUE_ERR_EN
    chk({tag, ".drop_err"}, 32'(drop_err), 32'(exp_drop));
`endif
  endtask

  // Inputs are set at the negedge. The model decides the handshakes from its
  // own state, advances one clock, and then checks.
  task automatic tick(input string tag);
    bit do_push;
    bit do_pop;
    #1;
    do_push = s_valid && !rst && (exp_cnt != DEPTH);
    do_pop  = m_ready && !rst && (exp_cnt != 0);
`ifdef SHIFT_CMD_QUEUE_ERR_EN
    if (rst) exp_drop = 1'b0;
    else if (s_valid && exp_cnt == DEPTH) exp_drop = 1'b1;
`endif
    if (do_pop) begin
      chk({tag, ".pop_data"}, 32'(m_data), 32'(sb[0].d));
      chk({tag, ".pop_shifted"}, 32'(shifter(m_data, m_shift)), 32'(shifter(sb[0].d, sb[0].s)));
      void'(sb.pop_front());
    end
    if (do_push) sb.push_back('{d: s_data, s: s_shift});
    @(posedge clk);
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      exp_cnt = exp_cnt + int'(do_push) - int'(do_pop);
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [SHIFT_W-1:0] s, input logic r);
    s_valid = v;
    s_data  = d;
    s_shift = s;
    m_ready = r;
  endtask

  logic [DATA_W-1:0] td [4];
  logic [SHIFT_W-1:0] ts [4];
  logic [DATA_W-1:0] shifted_exp [4];

  initial begin
    td = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    ts = '{3'd0, 3'd7, 3'd3, 3'd1};
    shifted_exp = '{8'h01, 8'h01, 8'h1F, 8'h1E};
`ifdef SHIFT_CMD_QUEUE_ERR_EN
    exp_drop = 1'b0;
`endif
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tick("reset0");
    tick("reset1");
    rst = 1'b0;
    #1;
    chk("reset_release.s_ready", 32'(s_ready), 32'h1);

    // Test 1: single push, FWFT head.
    drive(1'b1, 8'hB4, 3'd2, 1'b0);
    tick("t1_push");
    drive(1'b0, '0, '0, 1'b0);
    chk("t1_shifted", 32'(shifter(m_data, m_shift)), 32'h2D);
    tick("t1_stall");
    m_ready = 1'b1;
    tick("t1_pop");
    m_ready = 1'b0;

    // Test 2: fill to full, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, td[i], ts[i], 1'b0);
      tick("t2_fill");
    end
    chk("t2_full", 32'(full), 32'h1);
    chk("t2_s_ready", 32'(s_ready), 32'h0);
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_shift_out", 32'(shifter(m_data, m_shift)), 32'(shifted_exp[i]));
      tick("t2_drain");
    end
    chk("t2_empty", 32'(empty), 32'h1);
    tick("t2_empty_ready");

    // Full with simultaneous pop: no push this edge, s_ready returns next cycle.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h10 + 8'(i), 3'(i), 1'b0);
      tick("tf_fill");
    end
    drive(1'b1, 8'hEE, 3'd5, 1'b1);
    tick("tf_full_pop");
    drive(1'b1, 8'hEE, 3'd5, 1'b0);
    tick("tf_refill");
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) tick("tf_drain");

    // Test 3: push and pop together at count==1.
    drive(1'b1, 8'h5A, 3'd4, 1'b0);
    tick("t3_one");
    drive(1'b1, 8'hC3, 3'd6, 1'b1);
    tick("t3_both");
    chk("t3_head", 32'(m_data), 32'hC3);
    drive(1'b0, '0, '0, 1'b1);
    tick("t3_drain");

    // Test 4: streaming so both pointers wrap several times.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom_range(7)), 1'b1);
      tick("t4_stream");
    end
    drive(1'b0, '0, '0, 1'b1);
    tick("t4_drain");
    chk("t4_count0", 32'(count), 32'h0);

    // Test 5: reset with three queued entries.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 3'(i), 1'b0);
      tick("t5_fill");
    end
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_s_ready_in_rst", 32'(s_ready), 32'h0);
    tick("t5_rst");
    chk("t5_m_data0", 32'(m_data), 32'h0);
    rst = 1'b0;
    tick("t5_after");

`ifdef SHIFT_CMD_QUEUE_ERR_EN
    // Test 6: offering a command while full sets the sticky drop flag.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h70 + 8'(i), 3'(i), 1'b0);
      tick("t6_fill");
    end
    tick("t6_drop");
    chk("t6_drop_set", 32'(drop_err), 32'h1);
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) tick("t6_drain");
    chk("t6_drop_sticky", 32'(drop_err), 32'h1);
    rst = 1'b1;
    tick("t6_rst");
    rst = 1'b0;
    chk("t6_drop_clear", 32'(drop_err), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
